des_key_sched_rev: RTL
======================

// Module: des_key_sched_rev
// PURPOSE
//   Iterative DES key schedule. Loads one 64-bit key and streams the sixteen 48-bit round subkeys
//   over a valid/ready handshake, one subkey per accepted transfer.
//   Decrypt mode streams K16..K1 using right rotations; encrypt mode streams K1..K16 using left rotations.
//   Sits in front of the DES round datapath, which feeds each subkey into the S-box stage (sbox1..sbox8).
// PARAMETERS
//   KEY_PARITY_CHK  0  1 = check the odd parity of each key byte at load; 0 = key_par_err is tied to 0
// PORTS
//   clk          in   1   rising-edge clock, the only clock
//   rst_n        in   1   asynchronous, active-low reset
//   start        in   1   load request, sampled only in IDLE
//   decrypt      in   1   sampled with start: 1 = K16..K1 order, 0 = K1..K16 order
//   key_in       in   64  DES key; DES bit n is key_in[64-n], parity bits included
//   subkey       out  48  current round subkey; DES bit n is subkey[48-n]
//   subkey_valid out  1   subkey and round_idx are valid
//   subkey_ready in   1   consumer accepts; a transfer happens when valid & ready
//   round_idx    out  4   round number of the subkey minus 1 (0 = K1 .. 15 = K16)
//   last         out  1   high together with the 16th subkey of the stream
//   busy         out  1   high outside IDLE
//   done         out  1   one-cycle pulse after the 16th transfer
//   key_par_err  out  1   parity error, latched at load and held until the next load
// BEHAVIOUR
//   Reset: every output is 0, the FSM enters IDLE, and C, D and the counter clear. Reset acts
//     immediately at any point; a stream in progress is abandoned with no done pulse.
//   Tables: PC-1, PC-2 and the shift schedule are exactly as in FIPS 46-3.
//     Shift schedule: rounds 1, 2, 9 and 16 shift by 1; every other round shifts by 2.
//   FSM states: IDLE -> EMIT -> DONE -> IDLE.
//   IDLE, start=1 at edge t: {C,D} <= PC-1(key_in); mode latched; state <= EMIT.
//     Decrypt: round <= 16, and subkey is registered as PC-2(C0,D0). This is valid because the
//       total rotation over 16 rounds is 28, so C16=C0 and D16=D0.
//     Encrypt: round <= 1; C,D are rotated left by 1 before PC-2 is applied.
//     From t+1: subkey_valid=1, busy=1. Latency from start to the first valid is 1 cycle.
//   EMIT: subkey, round_idx and last are held stable while valid=1 and ready=0.
//     On a transfer of round r (decrypt, r>1): C,D rotate right by shift(r); round <= r-1.
//       The next subkey is valid on the following cycle with no bubble.
//     On a transfer of round r (encrypt, r<16): C,D rotate left by shift(r+1); round <= r+1.
//     On a transfer while last=1: valid <= 0, state <= DONE.
//   DONE: done=1 for exactly one cycle, busy=1, then IDLE with busy=0.
//   Throughput: 16 subkeys in 16 cycles when ready is held high; 18 cycles from start to idle.
//   start is ignored in EMIT and DONE. start in the DONE cycle is ignored and must be reasserted.
//   start and reset together: reset wins.
//   Rotations are 28-bit circular, applied to C and D separately.
//     round_idx wraps only through the explicit end-of-stream transition, never arithmetically.
//   Parity (KEY_PARITY_CHK=1): each byte must have an odd number of 1s. key_par_err is set if any
//     byte fails. The stream still runs; the error flag is informational only.
// TESTING
//   key 0x133457799BBCDFF1, decrypt=1, ready=1:
//     first subkey=0xCB3D8B0E17F5 with round_idx=15; 16th subkey=0x1B02EFFC7072 with round_idx=0
//     and last=1; done on the next cycle.
//   Same key, decrypt=0: first subkey=0x1B02EFFC7072 (idx 0), last subkey=0xCB3D8B0E17F5 (idx 15).
//     The full sequence must equal the decrypt sequence in reverse.
//   Backpressure: ready toggled randomly, including 5 low cycles on the 3rd subkey.
//     subkey must stay stable while stalled; still exactly 16 transfers and one done pulse.
//   start pulsed in EMIT with a different key: the stream is unchanged.
//     A new start one cycle after done loads the new key.
//   rst_n dropped asynchronously mid-stream (after 7 transfers): all outputs go to 0 with no clock
//     edge; a restart reproduces the full 16-key sequence from the beginning.
//   KEY_PARITY_CHK=1: 0x133457799BBCDFF1 -> key_par_err=0; 0x133457799BBCDFF0 -> key_par_err=1.
//     The subkeys are identical in both cases.

Source files
------------

// File: rtl/des_key_sched_rev_if.sv
// Handshake and key bus between the DES key scheduler and its consumer.
interface des_key_sched_rev_if;
  logic        start;
  logic        decrypt;
  logic [63:0] key_in;
  logic [47:0] subkey;
  logic        subkey_valid;
  logic        subkey_ready;
  logic [3:0]  round_idx;
  logic        last;
  logic        busy;
  logic        done;
  logic        key_par_err;

  modport master (
    output start, decrypt, key_in, subkey_ready,
    input  subkey, subkey_valid, round_idx, last, busy, done, key_par_err
  );
  modport slave (
    input  start, decrypt, key_in, subkey_ready,
    output subkey, subkey_valid, round_idx, last, busy, done, key_par_err
  );
endinterface

// File: rtl/des_key_sched_rev.sv
// Iterative DES key schedule: one PC-1 load, then one registered PC-2 subkey per transfer,
// walking K1..K16 (left rotations) or K16..K1 (right rotations).
module des_key_sched_rev #(
  parameter bit KEY_PARITY_CHK = 1'b0
) (
  input logic           clk,
  input logic           rst_n,
  des_key_sched_rev_if.slave ks
);
  localparam logic [1:0] IDLE = 2'd0, EMIT = 2'd1, DONE = 2'd2;

  // Tables hold DES (1-based, MSB-first) bit numbers exactly as published.
  localparam int PC1 [56] = '{57,49,41,33,25,17, 9, 1,58,50,42,34,26,18,
                              10, 2,59,51,43,35,27,19,11, 3,60,52,44,36,
                              63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                              14, 6,61,53,45,37,29,21,13, 5,28,20,12, 4};
  localparam int PC2 [48] = '{14,17,11,24, 1, 5, 3,28,15, 6,21,10,
                              23,19,12, 4,26, 8,16, 7,27,20,13, 2,
                              41,52,31,37,47,55,30,40,51,45,33,48,
                              44,49,39,56,34,53,46,42,50,36,29,32};

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) r[6'(55 - i)] = k[6'(64 - PC1[i])];
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] v);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) r[6'(47 - i)] = v[6'(56 - PC2[i])];
    return r;
  endfunction

  // C and D rotate independently; MSB of each half is DES bit 1 of that half.
  function automatic logic [55:0] rotcd(input logic [55:0] v, input logic left, input logic two);
    logic [27:0] c, d;
    c = v[55:28];
    d = v[27:0];
    if (left) begin
      c = two ? {c[25:0], c[27:26]} : {c[26:0], c[27]};
      d = two ? {d[25:0], d[27:26]} : {d[26:0], d[27]};
    end else begin
      c = two ? {c[1:0], c[27:2]} : {c[0], c[27:1]};
      d = two ? {d[1:0], d[27:2]} : {d[0], d[27:1]};
    end
    return {c, d};
  endfunction

  // Rounds 1, 2, 9, 16 (index 0, 1, 8, 15) shift by one.
  function automatic logic shift1(input logic [3:0] i);
    return (i == 4'd0) || (i == 4'd1) || (i == 4'd8) || (i == 4'd15);
  endfunction

  logic [1:0]  state;
  logic [55:0] cd, cd_nxt, k_pc1, k_rol1;
  logic [47:0] sk;
  logic [3:0]  idx;
  logic        mode, perr, par_bad, last_i, xfer;

  always_comb begin
    k_pc1  = pc1(ks.key_in);
    k_rol1 = rotcd(k_pc1, 1'b1, 1'b0);
    cd_nxt = mode ? rotcd(cd, 1'b0, !shift1(idx))
                  : rotcd(cd, 1'b1, !shift1(idx + 4'd1));
    last_i = (state == EMIT) && (mode ? (idx == 4'd0) : (idx == 4'd15));
    xfer   = (state == EMIT) && ks.subkey_ready;
  end

  always_comb begin
    par_bad = 1'b0;
    for (int b = 0; b < 8; b++) par_bad = par_bad | ~(^ks.key_in[8*b +: 8]);
    if (!KEY_PARITY_CHK) par_bad = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cd    <= '0;
      sk    <= '0;
      idx   <= '0;
      mode  <= 1'b0;
      perr  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (ks.start) begin
          mode  <= ks.decrypt;
          perr  <= par_bad;
          state <= EMIT;
          // Sixteen rounds rotate 28 positions in total, so C16/D16 equal C0/D0.
          if (ks.decrypt) begin
            cd  <= k_pc1;
            sk  <= pc2(k_pc1);
            idx <= 4'd15;
          end else begin
            cd  <= k_rol1;
            sk  <= pc2(k_rol1);
            idx <= 4'd0;
          end
        end
        EMIT: if (xfer) begin
          if (last_i) begin
            state <= DONE;
          end else begin
            cd  <= cd_nxt;
            sk  <= pc2(cd_nxt);
            idx <= mode ? idx - 4'd1 : idx + 4'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign ks.subkey       = sk;
  assign ks.subkey_valid = (state == EMIT);
  assign ks.round_idx    = idx;
  assign ks.last         = last_i;
  assign ks.busy         = (state != IDLE);
  assign ks.done         = (state == DONE);
  assign ks.key_par_err  = perr;
endmodule
